// File: rtl/jpeg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jpeg_pkg
// Purpose  : Shared types for the JPEG run-length encoding stage.
// Revision : 1.0 - initial release
// ============================================================================
package jpeg_pkg;

  localparam int COEF_W = 8;
  localparam int NCOEF  = 64;

  typedef logic signed [COEF_W-1:0] coef_t;

  typedef struct packed {
    logic       dc;
    logic [3:0] run;
    logic [3:0] size;
    logic [7:0] amp;
    logic       last;
  } sym_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/run_length_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : run_length_encoder_if
// Purpose  : Block-in / symbol-out handshake bundle for run_length_encoder.
// Revision : 1.0 - initial release
// ============================================================================
interface run_length_encoder_if;
  import jpeg_pkg::*;

  logic [COEF_W-1:0] z [0:NCOEF-1];
  logic              in_valid;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic              out_dc;
  logic [3:0]        out_run;
  logic [3:0]        out_size;
  logic [7:0]        out_amp;
  logic              out_last;

  modport master (
    output z, in_valid, out_ready,
    input  in_ready, out_valid, out_dc, out_run, out_size, out_amp, out_last
  );

  modport slave (
    input  z, in_valid, out_ready,
    output in_ready, out_valid, out_dc, out_run, out_size, out_amp, out_last
  );

endinterface
`default_nettype wire

// File: rtl/vlc_size_amp.sv
`default_nettype none
// ============================================================================
// Module   : vlc_size_amp
// Purpose  : Combinational JPEG size category and amplitude bits of a coefficient.
// Revision : 1.0 - initial release
// ============================================================================
module vlc_size_amp
  import jpeg_pkg::*;
(
  input  coef_t      i_coef,
  output logic [3:0] o_size,
  output logic [7:0] o_amp
);

  localparam int XW = COEF_W + 1;

  logic          w_neg;
  logic [XW-1:0] w_ext;
  logic [XW-1:0] w_abs;
  logic [XW-1:0] w_dec;
  logic [XW-1:0] w_mask;

  // Extra bit keeps |-128| representable.
  always_comb begin
    w_neg  = i_coef[COEF_W-1];
    w_ext  = {i_coef[COEF_W-1], i_coef};
    w_abs  = w_neg ? (~w_ext + XW'(1)) : w_ext;
    w_dec  = w_ext - XW'(1);
    o_size = 4'd0;
    for (int i = 0; i < XW; i++) begin
      if (w_abs[i]) o_size = 4'(i + 1);
    end
    w_mask = (XW'(1) << o_size) - XW'(1);
    o_amp  = w_neg ? (w_dec[7:0] & w_mask[7:0]) : i_coef[7:0];
  end

endmodule
`default_nettype wire

// File: rtl/run_length_encoder.sv
`default_nettype none
// ============================================================================
// Module   : run_length_encoder
// Purpose  : Turns a zigzag 8x8 block into DC / AC / ZRL / EOB entropy symbols.
// Revision : 1.0 - initial release
// ============================================================================
module run_length_encoder
  import jpeg_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  run_length_encoder_if.slave  bus
);

  state_t     r_state;
  state_t     w_state_nxt;
  coef_t      r_coef [0:NCOEF-1];
  logic [5:0] r_idx;
  logic [5:0] r_run;
  sym_t       r_out;
  logic       r_out_valid;

  logic [3:0] w_dc_size, w_ac_size;
  logic [7:0] w_dc_amp,  w_ac_amp;
  coef_t      w_cur;
  logic       w_accept, w_adv, w_cur_zero, w_last_idx, w_run_ge16;

  assign w_cur      = r_coef[r_idx];
  assign w_accept   = (r_state == IDLE) && bus.in_valid;
  assign w_adv      = !r_out_valid || bus.out_ready;
  assign w_cur_zero = (w_cur == '0);
  assign w_last_idx = (r_idx == 6'(NCOEF - 1));
  assign w_run_ge16 = (r_run[5:4] != 2'b00);

  vlc_size_amp u_dc (.i_coef(coef_t'(bus.z[0])), .o_size(w_dc_size), .o_amp(w_dc_amp));
  vlc_size_amp u_ac (.i_coef(w_cur),             .o_size(w_ac_size), .o_amp(w_ac_amp));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (bus.in_valid) w_state_nxt = SCAN;
      SCAN:    if (w_adv && w_last_idx && (w_cur_zero || !w_run_ge16)) w_state_nxt = FLUSH;
      FLUSH:   if (r_out_valid && bus.out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (r_state == IDLE);
    bus.out_valid = r_out_valid;
    bus.out_dc    = r_out.dc;
    bus.out_run   = r_out.run;
    bus.out_size  = r_out.size;
    bus.out_amp   = r_out.amp;
    bus.out_last  = r_out.last;
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int i = 0; i < NCOEF; i++) r_coef[i] <= coef_t'(bus.z[i]);
    end
  end

  // A new load overrides the valid clear from a same-cycle handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_idx       <= '0;
      r_run       <= '0;
    end else begin
      if (r_out_valid && bus.out_ready) r_out_valid <= 1'b0;
      if (w_accept) begin
        r_out       <= '{dc: 1'b1, run: 4'd0, size: w_dc_size, amp: w_dc_amp, last: 1'b0};
        r_out_valid <= 1'b1;
        r_idx       <= 6'd1;
        r_run       <= '0;
      end else if (r_state == SCAN && w_adv) begin
        if (w_cur_zero) begin
          if (w_last_idx) begin
            r_out       <= '{dc: 1'b0, run: 4'd0, size: 4'd0, amp: 8'd0, last: 1'b1};
            r_out_valid <= 1'b1;
          end else begin
            r_run <= r_run + 6'd1;
            r_idx <= r_idx + 6'd1;
          end
        end else if (w_run_ge16) begin
          r_out       <= '{dc: 1'b0, run: 4'd15, size: 4'd0, amp: 8'd0, last: 1'b0};
          r_out_valid <= 1'b1;
          r_run       <= r_run - 6'd16;
        end else begin
          r_out       <= '{dc: 1'b0, run: r_run[3:0], size: w_ac_size, amp: w_ac_amp,
                           last: w_last_idx};
          r_out_valid <= 1'b1;
          r_run       <= '0;
          if (!w_last_idx) r_idx <= r_idx + 6'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_run_length_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_run_length_encoder
// Purpose  : Directed self-checking bench for run_length_encoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_run_length_encoder;
  import jpeg_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  run_length_encoder_if bif ();
  run_length_encoder dut (.clk(clk), .rst_n(rst_n), .bus(bif));

  int          n_total = 0;
  int          n_pass  = 0;
  logic [7:0]  blk [64];
  logic [17:0] got [$];
  int          tim [$];
  logic [17:0] expq [$];
  bit          stall_ok, inrdy_ok;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  function automatic logic [17:0] mk(bit dc, int run, int size, int amp, bit last);
    return {dc, 4'(run), 4'(size), 8'(amp), last};
  endfunction

  function automatic logic [17:0] obs_sym();
    return {bif.out_dc, bif.out_run, bif.out_size, bif.out_amp, bif.out_last};
  endfunction

  task automatic clear_blk();
    for (int i = 0; i < 64; i++) blk[i] = 8'd0;
  endtask

  task automatic run_block(input bit rnd);
    logic [18:0] prev;
    bit          prev_stall;
    bit          done;
    logic        rdy;
    got.delete();
    tim.delete();
    stall_ok   = 1'b1;
    inrdy_ok   = 1'b1;
    done       = 1'b0;
    prev_stall = 1'b0;
    prev       = '0;
    for (int i = 0; i < 64; i++) bif.z[i] = blk[i];
    bif.in_valid = 1'b1;
    for (int w = 0; w < 20 && !bif.in_ready; w++) step();
    chk("in_ready_before_accept", 32'(bif.in_ready), 32'd1);
    step();
    bif.in_valid = 1'b0;
    for (int i = 0; i < 64; i++) bif.z[i] = 8'($urandom);
    chk("dc_latency_valid", 32'(bif.out_valid), 32'd1);
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      if (prev_stall && {bif.out_valid, obs_sym()} !== prev) stall_ok = 1'b0;
      if (bif.in_ready) inrdy_ok = 1'b0;
      rdy           = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bif.out_ready = rdy;
      prev_stall    = bif.out_valid && !rdy;
      prev          = {bif.out_valid, obs_sym()};
      if (bif.out_valid && rdy) begin
        got.push_back(obs_sym());
        tim.push_back(cyc);
        if (bif.out_last) done = 1'b1;
      end
      step();
    end
    bif.out_ready = 1'b1;
    chk("block_completed", 32'(done), 32'd1);
    chk("in_ready_after_last", 32'(bif.in_ready), 32'd1);
  endtask

  task automatic compare(input string tag);
    chk({tag, "_count"}, 32'(got.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size() && i < got.size(); i++)
      chk($sformatf("%s_sym%0d", tag, i), 32'(got[i]), 32'(expq[i]));
  endtask

  initial begin
    rst_n         = 1'b0;
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b1;
    for (int i = 0; i < 64; i++) bif.z[i] = 8'd0;
    repeat (3) step();
    chk("rst_out_valid", 32'(bif.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bif.in_ready),  32'd1);
    chk("rst_out_sym",   32'(obs_sym()),     32'd0);
    rst_n = 1'b1;
    step();

    // DC only, then EOB 63 cycles later
    clear_blk();
    blk[0] = 8'd5;
    run_block(1'b0);
    expq = '{mk(1, 0, 3, 5, 0), mk(0, 0, 0, 0, 1)};
    compare("dc_only");
    chk("eob_delay", 32'((tim.size() >= 2) ? (tim[1] - tim[0]) : -1), 32'd63);

    // -1 DC, small AC, ZRL then -128
    clear_blk();
    blk[0]  = 8'hFF;
    blk[1]  = 8'd3;
    blk[20] = 8'h80;
    run_block(1'b0);
    expq = '{mk(1, 0, 1, 0, 0), mk(0, 0, 2, 3, 0), mk(0, 15, 0, 0, 0),
             mk(0, 2, 8, 8'h7F, 0), mk(0, 0, 0, 0, 1)};
    compare("mixed");

    // Single nonzero in the last position: three ZRLs, no EOB
    clear_blk();
    blk[63] = 8'd1;
    run_block(1'b0);
    expq = '{mk(1, 0, 0, 0, 0), mk(0, 15, 0, 0, 0), mk(0, 15, 0, 0, 0),
             mk(0, 15, 0, 0, 0), mk(0, 14, 1, 1, 1)};
    compare("tail_one");

    // Every coefficient nonzero: value k+1 at index k
    for (int k = 0; k < 64; k++) blk[k] = 8'(k + 1);
    run_block(1'b0);
    expq.delete();
    for (int k = 0; k < 64; k++)
      expq.push_back(mk(k == 0, 0, $clog2(k + 2), k + 1, k == 63));
    compare("all_nz");

    // Same mixed block under random back-pressure
    clear_blk();
    blk[0]  = 8'hFF;
    blk[1]  = 8'd3;
    blk[20] = 8'h80;
    run_block(1'b1);
    expq = '{mk(1, 0, 1, 0, 0), mk(0, 0, 2, 3, 0), mk(0, 15, 0, 0, 0),
             mk(0, 2, 8, 8'h7F, 0), mk(0, 0, 0, 0, 1)};
    compare("stall_mixed");
    chk("stall_stable",       32'(stall_ok), 32'd1);
    chk("stall_in_ready_low", 32'(inrdy_ok), 32'd1);

    // Reset in the middle of a scan
    clear_blk();
    blk[5]  = 8'd7;
    blk[40] = 8'hFE;
    for (int i = 0; i < 64; i++) bif.z[i] = blk[i];
    bif.in_valid = 1'b1;
    step();
    bif.in_valid = 1'b0;
    repeat (10) step();
    rst_n = 1'b0;
    step();
    chk("midrst_out_valid", 32'(bif.out_valid), 32'd0);
    chk("midrst_in_ready",  32'(bif.in_ready),  32'd1);
    rst_n = 1'b1;
    clear_blk();
    blk[0] = 8'd5;
    run_block(1'b0);
    expq = '{mk(1, 0, 3, 5, 0), mk(0, 0, 0, 0, 1)};
    compare("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/run_length_encoder.md
# run_length_encoder

Sequential stage directly downstream of the zigzag reorder. It accepts one zigzag-ordered 8×8 block of 64 signed 8-bit quantized coefficients and emits the JPEG entropy symbol stream for that block:

- one DC symbol;
- AC (run, size, amplitude) symbols;
- ZRL for each run of 16 zeros;
- EOB, when the block ends in zeros.

Symbols leave one per handshake and feed the Huffman coder.

## Interface
Parameters:
- COEF_W, 8, coefficient width (two's complement)
- NCOEF, 64, coefficients per block

Ports:
- clk  in  1  single clock; everything is on the rising edge
- rst_n  in  1  synchronous, active-low reset
- z  in  [COEF_W-1:0] [0:NCOEF-1]  zigzag-ordered block; z[0] is DC
- in_valid  in  1  block on z is valid
- in_ready  out  1  block accepted on the edge where in_valid && in_ready
- out_valid  out  1  output symbol valid
- out_ready  in  1  consumer takes the symbol on the edge where out_valid && out_ready
- out_dc  out  1  symbol is the DC symbol
- out_run  out  4  zero run preceding the coefficient (0..15)
- out_size  out  4  size category (0..8)
- out_amp  out  8  amplitude bits, right-aligned; only the low out_size bits are meaningful
- out_last  out  1  final symbol of the block

## Operation
- States: IDLE, SCAN, FLUSH.
- Reset (rst_n=0 at an edge): state=IDLE, in_ready=1, and all out_* = 0.
- IDLE:
  - in_ready=1.
  - On accept: register all 64 coefficients, load the DC symbol into the output register, set idx=1, run=0, and go to SCAN.
  - DC symbol: out_dc=1, run=0, size and amp of z[0].
- SCAN: advances only when the output register is free, i.e. !out_valid, or out_valid && out_ready in the same cycle. Otherwise it holds. One action per advancing cycle, examining c=coef[idx]:
  - c==0, idx<63: run++, idx++, no symbol.
  - c==0, idx==63: load EOB (run 0, size 0, amp 0, out_last=1), go to FLUSH.
  - c!=0, run>=16: load ZRL (run 15, size 0, amp 0), run-=16, idx unchanged.
  - c!=0, run<16: load (run, size(c), amp(c)), run=0. If idx==63, set out_last=1 and go to FLUSH; otherwise idx++.
- Pending zero runs with no later nonzero never produce ZRL; they are absorbed by EOB.
- FLUSH: wait for the last symbol's handshake, then go to IDLE. in_ready=0 in SCAN and FLUSH.
- Size category: the bit length of |v|, with 0 mapping to 0. -128 maps to 8. Compute in COEF_W+1 bits.
- Amplitude:
  - v>0: v.
  - v<0: (v-1) masked to size bits. Example: -1 → amp 0; -128 → 0x7F.
- Output register is stable (all out_* unchanged) while out_valid && !out_ready.
- Reset mid-block discards the block and all pending symbols.

## Timing
- The DC symbol has out_valid=1 in the cycle immediately after the accepting edge.
- With out_ready held at 1:
  - each zero costs 1 cycle;
  - each emitted symbol costs 1 cycle;
  - each ZRL costs 1 extra cycle at the same idx.
- Worst case, a block takes 64 SCAN cycles plus up to 3 ZRL cycles.
- in_ready rises the cycle after the out_last handshake. No back-to-back overlap between blocks.
- The block register is loaded only on accept. z may change freely at other times.

## Structure
- Shared package jpeg_pkg holds:
  - COEF_W and NCOEF;
  - coef_t, a signed [7:0];
  - sym_t, a struct {dc, run, size, amp, last};
  - state enum {IDLE, SCAN, FLUSH}.
- Sub-module vlc_size_amp is combinational: coef_t in, size and amp out. It is instantiated once for the DC path and once for the SCAN path.
- Top level holds the FSM, the 64×8 block register, the idx counter (6 bits), the run counter (6 bits) and the output register.

## Test plan
- Block with z[0]=5 and all AC zero, out_ready=1:
  - expect DC (dc=1, size 3, amp 5);
  - then EOB with last=1 exactly 63 cycles later;
  - 2 symbols total.
- z[0]=-1, z[1]=3, z[20]=-128, rest 0:
  - expect DC (size 1, amp 0);
  - then (0,2,3);
  - then (18 zeros) ZRL (15,0,0) followed by (2,8,0x7F);
  - then EOB.
- z[63]=1, all else 0:
  - expect DC (size 0);
  - then ZRL ×3;
  - then (14,1,1) with last=1;
  - no EOB.
- All 64 nonzero (value k+1 at index k):
  - expect 64 symbols, all with run 0;
  - the last one is (0,7,64) with last=1.
- out_ready toggled randomly:
  - the symbol sequence is identical to the out_ready=1 run;
  - out_* are stable while stalled;
  - in_ready stays 0 until after the last handshake.
- rst_n pulsed low mid-SCAN:
  - next cycle out_valid=0 and in_ready=1;
  - a new block then encodes correctly from DC.
